// File: rtl/prob_circ_pkg.sv
// Shared IEEE-754 single-precision field constants, class enumeration and
// the saturating increment used by the product stream class counters.
package prob_circ_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'd255;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    NORMAL = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_class_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Purely combinational IEEE-754 single-precision classifier; the sign bit
// does not influence the class.
import prob_circ_pkg::*;

module fp_classify #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output fp_class_t        cls
);

  logic [FP_EXP_W-1:0]                   exp_f;
  logic [FP_MANT_W-1:0]                  mant_f;
  logic [WIDTH-FP_EXP_W-FP_MANT_W-1:0]   unused_sign;

  assign exp_f       = word[FP_MANT_W +: FP_EXP_W];
  assign mant_f      = word[FP_MANT_W-1:0];
  assign unused_sign = word[WIDTH-1:FP_EXP_W+FP_MANT_W];

  // NOTE: cls gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = (mant_f == '0) ? ZERO : DENORM;
    end else if (exp_f == FP_EXP_MAX) begin
      cls = (mant_f == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/product_stream_fifo.sv
// Strobe/ack FIFO between the multiplier product and the file writer,
// with saturating per-class counters for every accepted word.
import prob_circ_pkg::*;

module product_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          input_a,
  input  logic                      input_a_stb,
  output logic                      input_a_ack,
  output logic [WIDTH-1:0]          output_z,
  output logic                      output_z_stb,
  input  logic                      output_z_ack,
  output logic [$clog2(DEPTH):0]    count,
  output logic [STAT_W-1:0]         zero_cnt,
  output logic [STAT_W-1:0]         inf_cnt,
  output logic [STAT_W-1:0]         nan_cnt,
  output logic [STAT_W-1:0]         denorm_cnt,
  input  logic                      clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  fp_class_t        in_class;

  // Handshake outputs depend only on registered occupancy, never on the strobes.
  assign input_a_ack  = (count != FULL_CNT);
  assign output_z_stb = (count != '0);
  assign output_z     = mem[rd_ptr];

  assign push = input_a_stb  & input_a_ack;
  assign pop  = output_z_stb & output_z_ack;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // already mark it empty, and a resettable array costs far more flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_a;
  end

  fp_classify #(.WIDTH(WIDTH)) u_classify (
    .word (input_a),
    .cls  (in_class)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_cnt   <= '0;
      inf_cnt    <= '0;
      nan_cnt    <= '0;
      denorm_cnt <= '0;
    end else if (clr_stats) begin
      zero_cnt   <= '0;
      inf_cnt    <= '0;
      nan_cnt    <= '0;
      denorm_cnt <= '0;
    end else if (push) begin
      case (in_class)
        ZERO:    zero_cnt   <= sat_inc(zero_cnt);
        INF:     inf_cnt    <= sat_inc(inf_cnt);
        NAN:     nan_cnt    <= sat_inc(nan_cnt);
        DENORM:  denorm_cnt <= sat_inc(denorm_cnt);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_stream_fifo.sv
// Self-checking bench for product_stream_fifo: directed scenarios plus
// random traffic compared against a queue-based reference model.
module tb_product_stream_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       input_a;
  logic                   input_a_stb;
  logic                   input_a_ack;
  logic [WIDTH-1:0]       output_z;
  logic                   output_z_stb;
  logic                   output_z_ack;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            zero_cnt;
  logic [15:0]            inf_cnt;
  logic [15:0]            nan_cnt;
  logic [15:0]            denorm_cnt;
  logic                   clr_stats;

  product_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .count        (count),
    .zero_cnt     (zero_cnt),
    .inf_cnt      (inf_cnt),
    .nan_cnt      (nan_cnt),
    .denorm_cnt   (denorm_cnt),
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of words and four saturating class tallies.
  logic [31:0] model_q [$];
  int m_zero, m_inf, m_nan, m_denorm;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // 0 zero, 1 denormal, 2 normal, 3 infinity, 4 nan
  function automatic int fp_kind(input logic [31:0] w);
    int e;
    int m;
    e = int'((w >> 23) % 256);
    m = int'(w % 32'h0080_0000);
    if (e == 0)   return (m == 0) ? 0 : 1;
    if (e == 255) return (m == 0) ? 3 : 4;
    return 2;
  endfunction

  function automatic int bump(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_zero = 0; m_inf = 0; m_nan = 0; m_denorm = 0;
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(model_q.size()));
    check("in_ack", 32'(input_a_ack), 32'(model_q.size() != DEPTH));
    check("out_stb", 32'(output_z_stb), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("head", output_z, model_q[0]);
    check("zero_cnt", 32'(zero_cnt), 32'(m_zero));
    check("inf_cnt", 32'(inf_cnt), 32'(m_inf));
    check("nan_cnt", 32'(nan_cnt), 32'(m_nan));
    check("denorm_cnt", 32'(denorm_cnt), 32'(m_denorm));
  endtask

  // Called at posedge+1: apply inputs, optionally compare, clock, update model.
  task automatic cycle(input logic stb, input logic [31:0] data, input logic ack,
                       input logic clr, input bit verify);
    bit do_push;
    bit do_pop;
    input_a_stb  = stb;
    input_a      = data;
    output_z_ack = ack;
    clr_stats    = clr;
    if (verify) check_outputs();
    do_push = stb && (model_q.size() < DEPTH);
    do_pop  = ack && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(data);
    if (clr) begin
      m_zero = 0; m_inf = 0; m_nan = 0; m_denorm = 0;
    end else if (do_push) begin
      case (fp_kind(data))
        0: m_zero   = bump(m_zero);
        1: m_denorm = bump(m_denorm);
        3: m_inf    = bump(m_inf);
        4: m_nan    = bump(m_nan);
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && model_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("drained", 32'(count), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return {r[31], 8'hFF, 23'h0};
      3: return {r[31], 8'hFF, r[22:1], 1'b1};
      4: return {r[31], 8'h00, r[22:1], 1'b1};
      default: return r;
    endcase
  endfunction

  logic [31:0] seq3 [3];

  initial begin
    model_reset();
    rst = 1'b0; input_a = '0; input_a_stb = 1'b0; output_z_ack = 1'b0; clr_stats = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ack", 32'(input_a_ack), 32'd1);
    check("rst_stb", 32'(output_z_stb), 32'd0);
    check("rst_zero", 32'(zero_cnt), 32'd0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Three normal words queued, then drained in order.
    seq3[0] = 32'h3F80_0000; seq3[1] = 32'h4000_0000; seq3[2] = 32'h4040_0000;
    for (int i = 0; i < 3; i++) cycle(1'b1, seq3[i], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("r30_count", 32'(count), 32'(3 - i));
      check("r30_head", output_z, seq3[i]);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("r30_empty", 32'(count), 32'd0);
    check("r30_zero", 32'(zero_cnt), 32'd0);

    // Fill completely; a held ninth word waits until the cycle after the first pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h4100_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    check("r31_full", 32'(count), 32'(DEPTH));
    check("r31_ack", 32'(input_a_ack), 32'd0);
    cycle(1'b1, 32'h4200_0000, 1'b0, 1'b0, 1'b1);
    check("r31_hold", 32'(count), 32'(DEPTH));
    cycle(1'b1, 32'h4200_0000, 1'b1, 1'b0, 1'b1);
    check("r31_after_pop", 32'(count), 32'(DEPTH - 1));
    check("r31_ack_back", 32'(input_a_ack), 32'd1);
    cycle(1'b1, 32'h4200_0000, 1'b0, 1'b0, 1'b1);
    check("r31_refill", 32'(count), 32'(DEPTH));
    drain();

    // Class counting on special values.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    check("r32_zero", 32'(zero_cnt), 32'd2);
    check("r32_inf", 32'(inf_cnt), 32'd1);
    check("r32_nan", 32'(nan_cnt), 32'd1);
    check("r32_denorm", 32'(denorm_cnt), 32'd1);
    drain();

    // Steady streaming at occupancy 4; pointers wrap several times.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h4500_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'h4600_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
      check("r33_count", 32'(count), 32'd4);
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0), 1'b1);
    drain();

    // Asynchronous reset with five words stored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h4700_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    check("r34_pre", 32'(count), 32'd5);
    input_a_stb = 1'b0; output_z_ack = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("r34_stb_drop", 32'(output_z_stb), 32'd0);
    check("r34_count", 32'(count), 32'd0);
    check("r34_ack", 32'(input_a_ack), 32'd1);
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 32'hC0A0_0000, 1'b0, 1'b0, 1'b1);
    check("r34_first", output_z, 32'hC0A0_0000);
    check("r34_cnt1", 32'(count), 32'd1);
    drain();

    // Saturation of zero_cnt, then clear beating a simultaneous zero push.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check("r35_at_max", 32'(zero_cnt), 32'h0000_FFFF);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    check("r35_saturated", 32'(zero_cnt), 32'h0000_FFFF);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    check("r35_cleared", 32'(zero_cnt), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
